top2_sched: RTL and testbench

Multi-channel scheduler for the running top-two tracker. `NUM_CH` independent requester streams share one top-two update unit. A round-robin arbiter grants one stream per cycle, and the scheduler holds each channel's largest and second-largest values. It reports the post-update result of every accepted sample on a single registered result port.

---
 rtl/top2_sched_pkg.sv | 20 ++
 rtl/top2_sched_update.sv | 30 +++
 rtl/top2_sched.sv | 131 +++++++++++++
 tb/tb_top2_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/top2_sched_pkg.sv
// Shared types and helpers for the top2_sched multi-channel top-two scheduler.
// Optional feature macro: TOP2_SCHED_COUNT_EN adds per-channel accepted-sample counters.
package top2_sched_pkg;

    localparam int DATA_W  = 32;
    localparam int COUNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0]  max;
        logic [DATA_W-1:0]  second;
`ifdef TOP2_SCHED_COUNT_EN
        logic [COUNT_W-1:0] count;
`endif
    } ch_state_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/top2_sched_update.sv
// Combinational single-channel top-two update; a same-cycle clear wipes the old state before the sample lands.
// Optional feature macro: TOP2_SCHED_COUNT_EN (saturating accepted-sample count).
module top2_update
    import top2_sched_pkg::*;
(
    input  ch_state_t         i_state,
    input  logic [DATA_W-1:0] i_d,
    input  logic              i_clr,
    output ch_state_t         o_next
);

    ch_state_t w_base;

    always_comb begin
        w_base = i_clr ? '0 : i_state;
        o_next = w_base;
        if (i_d > w_base.max) begin
            o_next.max    = i_d;
            o_next.second = w_base.max;
        end else if (i_d > w_base.second) begin
            o_next.second = i_d;
        end
`ifdef TOP2_SCHED_COUNT_EN
        if (w_base.count != '1) begin
            o_next.count = w_base.count + COUNT_W'(1);
        end
`endif
    end

endmodule

// File: rtl/top2_sched.sv
// Round-robin scheduler sharing one top-two update unit across NUM_CH streams; one registered result per accepted sample.
// Optional feature macro: TOP2_SCHED_COUNT_EN adds out_count.
module top2_sched
    import top2_sched_pkg::*;
#(
    // DATA_WIDTH must match the package sample width used by ch_state_t.
    parameter int DATA_WIDTH = DATA_W,
    parameter int NUM_CH     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH-1:0]              clr,
    output logic                           out_valid,
    output logic [ch_idx_w(NUM_CH)-1:0]    out_ch,
    output logic [DATA_WIDTH-1:0]          out_max,
    output logic [DATA_WIDTH-1:0]          out_second
`ifdef TOP2_SCHED_COUNT_EN
    ,
    output logic [COUNT_W-1:0]             out_count
`endif
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    ch_state_t               r_state [NUM_CH];
    logic [CH_W-1:0]         r_ptr;
    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic [DATA_WIDTH-1:0]   r_out_max;
    logic [DATA_WIDTH-1:0]   r_out_second;
`ifdef TOP2_SCHED_COUNT_EN
    logic [COUNT_W-1:0]      r_out_count;
`endif

    logic                    w_found;
    logic [CH_W-1:0]         w_gidx;
    logic [CH_W-1:0]         w_cand;
    logic [NUM_CH-1:0]       w_ready;
    logic                    w_hs;
    ch_state_t               w_cur;
    ch_state_t               w_next;
    logic [DATA_WIDTH-1:0]   w_din;

    // First valid channel at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = CH_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_found && !reset) begin
            w_ready[w_gidx] = 1'b1;
        end
    end

    assign in_ready = w_ready;
    assign w_hs     = w_found && !reset;
    assign w_cur    = r_state[w_gidx];
    assign w_din    = in_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];

    top2_update u_update (
        .i_state (w_cur),
        .i_d     (w_din),
        .i_clr   (clr[w_gidx]),
        .o_next  (w_next)
    );

    // Clears on non-granted channels act independently of the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= '0;
            end
            r_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hs && (w_gidx == CH_W'(i))) begin
                    r_state[i] <= w_next;
                end else if (clr[i]) begin
                    r_state[i] <= '0;
                end
            end
            if (w_hs) begin
                r_ptr <= (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_max    <= '0;
            r_out_second <= '0;
`ifdef TOP2_SCHED_COUNT_EN
            r_out_count  <= '0;
`endif
        end else begin
            r_out_valid <= w_hs;
            if (w_hs) begin
                r_out_ch     <= w_gidx;
                r_out_max    <= w_next.max;
                r_out_second <= w_next.second;
`ifdef TOP2_SCHED_COUNT_EN
                r_out_count  <= w_next.count;
`endif
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_max    = r_out_max;
    assign out_second = r_out_second;
`ifdef TOP2_SCHED_COUNT_EN
    assign out_count  = r_out_count;
`endif

endmodule

// File: tb/tb_top2_sched.sv
// Directed-vector bench for top2_sched (NUM_CH=4, DATA_WIDTH=32).
// Counter checks are compiled only when TOP2_SCHED_COUNT_EN is defined.
module tb_top2_sched;

    localparam int NC = 4;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    in_valid;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]    in_ready;
    logic [NC-1:0]    clr;
    logic             out_valid;
    logic [1:0]       out_ch;
    logic [DW-1:0]    out_max;
    logic [DW-1:0]    out_second;
`ifdef TOP2_SCHED_COUNT_EN
    logic [15:0]      out_count;
`endif

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    top2_sched #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_max    (out_max),
        .out_second (out_second)
`ifdef TOP2_SCHED_COUNT_EN
        ,
        .out_count  (out_count)
`endif
    );

    typedef struct {
        logic          rst;
        logic [NC-1:0] clr;
        logic [NC-1:0] valid;
        logic [NC*DW-1:0] data;
        logic [NC-1:0] eReady;
        logic          eValid;
        logic [1:0]    eCh;
        logic [DW-1:0] eMax;
        logic [DW-1:0] eSec;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic rst, input logic [3:0] c, input logic [3:0] v,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] er, input logic ev, input logic [1:0] ech,
                                input logic [31:0] emax, input logic [31:0] esec);
        vec_t r;
        r.rst = rst; r.clr = c; r.valid = v; r.data = {d3, d2, d1, d0};
        r.eReady = er; r.eValid = ev; r.eCh = ech; r.eMax = emax; r.eSec = esec;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int row);
        @(negedge clk);
        reset    = v.rst;
        clr      = v.clr;
        in_valid = v.valid;
        in_data  = v.data;
        #1;
        checkOutput("in_ready", row, 64'(in_ready), 64'(v.eReady));
        @(posedge clk);
        #1;
        checkOutput("out_valid",  row, 64'(out_valid),  64'(v.eValid));
        checkOutput("out_ch",     row, 64'(out_ch),     64'(v.eCh));
        checkOutput("out_max",    row, 64'(out_max),    64'(v.eMax));
        checkOutput("out_second", row, 64'(out_second), 64'(v.eSec));
    endtask

    // One ch2-only sample with optional same-cycle clear; returns after outputs settle.
    task automatic sendCh2(input logic [31:0] d, input logic doClr);
        @(negedge clk);
        clr      = doClr ? 4'b0100 : 4'b0000;
        in_valid = 4'b0100;
        in_data  = {32'd0, d, 32'd0, 32'd0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 4'b0000, 4'b0001, 5, 0, 0, 0,            4'b0001, 1, 0, 5, 0);
        vecs[1]  = mk(0, 4'b0000, 4'b0001, 9, 0, 0, 0,            4'b0001, 1, 0, 9, 5);
        vecs[2]  = mk(0, 4'b0000, 4'b0001, 9, 0, 0, 0,            4'b0001, 1, 0, 9, 9);
        vecs[3]  = mk(0, 4'b0000, 4'b0001, 3, 0, 0, 0,            4'b0001, 1, 0, 9, 9);
        vecs[4]  = mk(0, 4'b0000, 4'b0000, 7, 7, 7, 7,            4'b0000, 0, 0, 9, 9);
        vecs[5]  = mk(0, 4'b0001, 4'b0000, 0, 0, 0, 0,            4'b0000, 0, 0, 9, 9);
        vecs[6]  = mk(0, 4'b0000, 4'b0001, 5, 0, 0, 0,            4'b0001, 1, 0, 5, 0);
        vecs[7]  = mk(0, 4'b0000, 4'b0001, 9, 0, 0, 0,            4'b0001, 1, 0, 9, 5);
        vecs[8]  = mk(1, 4'b0000, 4'b1111, 3, 10, 6, 8,           4'b0000, 0, 0, 0, 0);
        vecs[9]  = mk(0, 4'b0000, 4'b1111, 3, 10, 6, 8,           4'b0001, 1, 0, 3, 0);
        vecs[10] = mk(0, 4'b0000, 4'b1111, 3, 10, 6, 8,           4'b0010, 1, 1, 10, 0);
        vecs[11] = mk(0, 4'b0000, 4'b1111, 3, 10, 6, 8,           4'b0100, 1, 2, 6, 0);
        vecs[12] = mk(0, 4'b0000, 4'b1111, 3, 10, 6, 8,           4'b1000, 1, 3, 8, 0);
        vecs[13] = mk(0, 4'b0000, 4'b1111, 9, 4, 1, 8,            4'b0001, 1, 0, 9, 3);
        vecs[14] = mk(0, 4'b0000, 4'b1111, 9, 4, 1, 8,            4'b0010, 1, 1, 10, 4);
        vecs[15] = mk(0, 4'b0000, 4'b1111, 9, 4, 1, 8,            4'b0100, 1, 2, 6, 1);
        vecs[16] = mk(0, 4'b0000, 4'b1000, 0, 0, 0, 8,            4'b1000, 1, 3, 8, 8);
        vecs[17] = mk(0, 4'b0000, 4'b0100, 0, 0, 7, 0,            4'b0100, 1, 2, 7, 6);
        vecs[18] = mk(0, 4'b0000, 4'b1010, 0, 99, 0, 2,           4'b1000, 1, 3, 8, 8);
        vecs[19] = mk(0, 4'b0000, 4'b0010, 0, 0, 0, 0,            4'b0010, 1, 1, 10, 4);
        vecs[20] = mk(0, 4'b0010, 4'b0010, 0, 2, 0, 0,            4'b0010, 1, 1, 2, 0);
        vecs[21] = mk(0, 4'b0000, 4'b0010, 0, 1, 0, 0,            4'b0010, 1, 1, 2, 1);
        vecs[22] = mk(0, 4'b0000, 4'b0001, 0, 0, 0, 0,            4'b0001, 1, 0, 9, 3);
        vecs[23] = mk(0, 4'b0100, 4'b0001, 3, 0, 0, 0,            4'b0001, 1, 0, 9, 3);
        vecs[24] = mk(0, 4'b0000, 4'b0100, 0, 0, 5, 0,            4'b0100, 1, 2, 5, 0);
        vecs[25] = mk(0, 4'b0000, 4'b0100, 0, 0, 32'hFFFF_FFFF, 0, 4'b0100, 1, 2, 32'hFFFF_FFFF, 5);
        vecs[26] = mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0,            4'b0000, 0, 2, 32'hFFFF_FFFF, 5);
        vecs[27] = mk(0, 4'b0000, 4'b1000, 0, 0, 0, 4,            4'b1000, 1, 3, 4, 0);

        reset    = 1'b1;
        clr      = '0;
        in_valid = 4'b1111;
        in_data  = {32'd4, 32'd3, 32'd2, 32'd1};
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset in_ready",   -1, 64'(in_ready),   64'd0);
        checkOutput("reset out_valid",  -1, 64'(out_valid),  64'd0);
        checkOutput("reset out_ch",     -1, 64'(out_ch),     64'd0);
        checkOutput("reset out_max",    -1, 64'(out_max),    64'd0);
        checkOutput("reset out_second", -1, 64'(out_second), 64'd0);

        for (int r = 0; r < 28; r++) begin
            applyStimulus(vecs[r], r);
        end

        // Fairness under saturation: grants rotate 0..3 and results trail by one cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset    = 1'b0;
            clr      = '0;
            in_valid = 4'b1111;
            in_data  = '0;
            #1;
            checkOutput("rr onehot", 100 + i, 64'($onehot(in_ready)), 64'd1);
            checkOutput("rr grant",  100 + i, 64'(in_ready), 64'(4'b0001 << (i % 4)));
            @(posedge clk);
            #1;
            checkOutput("rr out_valid", 100 + i, 64'(out_valid), 64'd1);
            checkOutput("rr out_ch",    100 + i, 64'(out_ch),    64'(i % 4));
        end

`ifdef TOP2_SCHED_COUNT_EN
        sendCh2(32'd1, 1'b1);
        checkOutput("count clr+hs", 200, 64'(out_count), 64'd1);
        sendCh2(32'd2, 1'b0);
        checkOutput("count 2", 201, 64'(out_count), 64'd2);
        sendCh2(32'd3, 1'b0);
        checkOutput("count 3", 202, 64'(out_count), 64'd3);
        @(negedge clk);
        clr      = 4'b0100;
        in_valid = '0;
        @(posedge clk);
        sendCh2(32'd4, 1'b0);
        checkOutput("count after clr", 203, 64'(out_count), 64'd1);
        @(negedge clk);
        in_valid = '0;
        clr      = '0;
        dut.r_state[2].count = 16'hFFFF;
        sendCh2(32'd5, 1'b0);
        checkOutput("count saturate", 204, 64'(out_count), 64'hFFFF);
`endif

        @(negedge clk);
        in_valid = '0;
        clr      = '0;
        @(posedge clk);
        #1;
        checkOutput("idle out_valid", 300, 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
